// File: rtl/cache_refill_arbiter_if.sv
// Refill read channel shared by a cache and a memory bridge.
// The requester side (cache, or the arbiter toward memory) uses the master modport.
interface cache_refill_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              rd_req;
   logic [2:0]        rd_type;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_rdy;
   logic              ret_valid;
   logic              ret_last;
   logic [DATA_W-1:0] ret_data;

   modport master (
      output rd_req, rd_type, rd_addr,
      input  rd_rdy, ret_valid, ret_last, ret_data
   );

   modport slave (
      input  rd_req, rd_type, rd_addr,
      output rd_rdy, ret_valid, ret_last, ret_data
   );
endinterface

// File: rtl/cache_refill_arbiter.sv
// Shares a single refill read port between ICache and DCache.
// One burst in flight at a time; DCache has priority unless ICache has waited too long.
module cache_refill_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   cache_refill_arbiter_if.slave  inst,
   cache_refill_arbiter_if.slave  data,
   cache_refill_arbiter_if.master mem
);

   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              owner_data_q, owner_data_d;  // 0: ICache owns the burst
   logic [2:0]        type_q, type_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  starve_q, starve_d;

   logic grant_inst;
   logic grant_data;
   logic inst_busy;
   logic in_req;
   logic in_resp;

   // Arbitration, only evaluated while idle
   always_comb begin
      grant_inst = 1'b0;
      grant_data = 1'b0;
      if (state_q == ST_IDLE) begin
         if (inst.rd_req && (!data.rd_req || (starve_q >= STARVE_LIM))) begin
            grant_inst = 1'b1;
         end else if (data.rd_req) begin
            grant_data = 1'b1;
         end
      end
   end

   // Next-state: burst FSM, latched request, ICache starvation counter
   always_comb begin
      state_d      = state_q;
      owner_data_d = owner_data_q;
      type_d       = type_q;
      addr_d       = addr_q;
      starve_d     = starve_q;

      case (state_q)
         ST_IDLE: begin
            if (grant_inst) begin
               state_d      = ST_REQ;
               owner_data_d = 1'b0;
               type_d       = inst.rd_type;
               addr_d       = inst.rd_addr;
            end else if (grant_data) begin
               state_d      = ST_REQ;
               owner_data_d = 1'b1;
               type_d       = data.rd_type;
               addr_d       = data.rd_addr;
            end
         end
         ST_REQ: begin
            if (mem.rd_rdy) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (mem.ret_valid && mem.ret_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // ICache holding its request during its own burst is not waiting
      if (grant_inst) begin
         starve_d = '0;
      end else if (inst.rd_req && !inst_busy && (starve_q < STARVE_LIM)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   assign inst_busy = (state_q != ST_IDLE) && !owner_data_q;

   // State registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= ST_IDLE;
         owner_data_q <= 1'b0;
         type_q       <= '0;
         addr_q       <= '0;
         starve_q     <= '0;
      end else begin
         state_q      <= state_d;
         owner_data_q <= owner_data_d;
         type_q       <= type_d;
         addr_q       <= addr_d;
         starve_q     <= starve_d;
      end
   end

   assign in_req  = (state_q == ST_REQ);
   assign in_resp = (state_q == ST_RESP);

   // Route handshake and return beats to the burst owner only
   always_comb begin
      mem.rd_req      = in_req;
      mem.rd_type     = type_q;
      mem.rd_addr     = addr_q;

      inst.rd_rdy     = in_req && !owner_data_q && mem.rd_rdy;
      data.rd_rdy     = in_req && owner_data_q && mem.rd_rdy;

      inst.ret_valid  = in_resp && !owner_data_q && mem.ret_valid;
      inst.ret_last   = in_resp && !owner_data_q && mem.ret_valid && mem.ret_last;
      data.ret_valid  = in_resp && owner_data_q && mem.ret_valid;
      data.ret_last   = in_resp && owner_data_q && mem.ret_valid && mem.ret_last;

      // Data is broadcast; each cache qualifies it with its own valid
      inst.ret_data   = in_resp ? mem.ret_data : '0;
      data.ret_data   = in_resp ? mem.ret_data : '0;
   end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Bench for cache_refill_arbiter: directed table, corner sequences, random traffic
// checked every cycle against a transaction-level model.
module tb_cache_refill_arbiter;

   localparam int unsigned STARVE_MAX = 8;

   logic aclk = 1'b0;
   logic aresetn;
   always #5 aclk = ~aclk;

   cache_refill_arbiter_if inst_if ();
   cache_refill_arbiter_if data_if ();
   cache_refill_arbiter_if mem_if ();

   cache_refill_arbiter #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .aclk   (aclk),
      .aresetn(aresetn),
      .inst   (inst_if),
      .data   (data_if),
      .mem    (mem_if)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: one outstanding burst, accepted or not yet, plus ICache wait count
   bit          m_busy   = 1'b0;
   bit          m_acc    = 1'b0;
   bit          m_own_d  = 1'b0;
   logic [2:0]  m_type   = '0;
   logic [31:0] m_addr   = '0;
   int          m_wait   = 0;

   // Bridge stimulus state
   int  beats = 0;
   bit  rnd   = 1'b0;
   bit  last_irdy, last_drdy;

   typedef struct {
      logic        i_req;
      logic        d_req;
      logic [31:0] i_addr;
      logic [31:0] d_addr;
      logic        m_rdy;
      logic        m_rv;
      logic        m_rl;
      logic [31:0] m_data;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_irdy;
      logic        e_drdy;
      logic        e_irv;
      logic        e_irl;
      logic        e_drv;
      logic        e_drl;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] dut_out();
      return {22'b0, mem_if.rd_req, mem_if.rd_type, mem_if.rd_addr,
              inst_if.rd_rdy, inst_if.ret_valid, inst_if.ret_last, inst_if.ret_data,
              data_if.rd_rdy, data_if.ret_valid, data_if.ret_last, data_if.ret_data};
   endfunction

   function automatic logic [127:0] model_out();
      logic        req_ph, resp_ph, i_own, d_own, rv, rl;
      logic [31:0] dat;
      if (!aresetn) return '0;
      req_ph  = m_busy && !m_acc;
      resp_ph = m_busy && m_acc;
      i_own   = !m_own_d;
      d_own   = m_own_d;
      rv      = resp_ph && mem_if.ret_valid;
      rl      = rv && mem_if.ret_last;
      dat     = resp_ph ? mem_if.ret_data : 32'h0;
      return {22'b0, req_ph, m_type, m_addr,
              req_ph && i_own && mem_if.rd_rdy, rv && i_own, rl && i_own, dat,
              req_ph && d_own && mem_if.rd_rdy, rv && d_own, rl && d_own, dat};
   endfunction

   task automatic model_step();
      bit win_inst;
      if (!aresetn) begin
         m_busy = 0; m_acc = 0; m_own_d = 0; m_type = '0; m_addr = '0; m_wait = 0;
      end else if (!m_busy) begin
         if (inst_if.rd_req || data_if.rd_req) begin
            win_inst = inst_if.rd_req && (!data_if.rd_req || m_wait >= STARVE_MAX);
            m_busy  = 1;
            m_acc   = 0;
            m_own_d = !win_inst;
            m_type  = win_inst ? inst_if.rd_type : data_if.rd_type;
            m_addr  = win_inst ? inst_if.rd_addr : data_if.rd_addr;
            if (win_inst) m_wait = 0;
            else if (inst_if.rd_req && m_wait < STARVE_MAX) m_wait++;
         end
      end else begin
         if (inst_if.rd_req && m_own_d && m_wait < STARVE_MAX) m_wait++;
         if (!m_acc) begin
            if (mem_if.rd_rdy) m_acc = 1;
         end else if (mem_if.ret_valid && mem_if.ret_last) begin
            m_busy = 0;
         end
      end
   endtask

   // One clock: compare against model, advance model, return at next falling edge
   task automatic cycle();
      #1;
      chk("model", dut_out(), model_out());
      model_step();
      @(negedge aclk);
   endtask

   // Cycle with a simple bridge driving return beats; caches drop requests after rdy
   task automatic bus_cycle();
      bit acc, stray;
      if (beats > 0) begin
         mem_if.ret_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         mem_if.ret_last  = mem_if.ret_valid && (beats == 1);
      end else begin
         stray = rnd && ($urandom_range(0, 7) == 0);
         mem_if.ret_valid = stray;
         mem_if.ret_last  = stray && 1'($urandom_range(0, 1));
      end
      mem_if.ret_data = $urandom;
      #1;
      acc       = mem_if.rd_req && mem_if.rd_rdy;
      last_irdy = inst_if.rd_rdy;
      last_drdy = data_if.rd_rdy;
      cycle();
      if (beats > 0 && mem_if.ret_valid) beats--;
      if (acc) beats = rnd ? $urandom_range(1, 4) : 4;
      if (last_irdy) inst_if.rd_req = 1'b0;
      if (last_drdy) data_if.rd_req = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < n; k++) bus_cycle();
   endtask

   initial begin
      int n_data;
      bit got;
      bit seen;
      aresetn          = 1'b0;
      inst_if.rd_req   = 0; inst_if.rd_type = 3'b100; inst_if.rd_addr = '0;
      data_if.rd_req   = 0; data_if.rd_type = 3'b001; data_if.rd_addr = '0;
      mem_if.rd_rdy    = 0; mem_if.ret_valid = 0; mem_if.ret_last = 0; mem_if.ret_data = '0;
      @(negedge aclk);
      #1;
      chk("reset_outputs", dut_out(), 128'h0);
      cycle();
      aresetn = 1'b1;

      // i_req d_req i_addr d_addr m_rdy m_rv m_rl m_data | e_req e_addr irdy drdy irv irl drv drl
      tbl.push_back('{1, 0, 32'h1C000000, 0, 0, 0, 0, 0,           0, 0,            0, 0, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 32'h1C000000, 0, 0, 0, 0, 0,           1, 32'h1C000000, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 32'h1C000000, 0, 1, 0, 0, 0,           1, 32'h1C000000, 1, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0,          0, 1, 0, 32'hA0,        0, 0,            0, 0, 1, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0,          0, 1, 0, 32'hA1,        0, 0,            0, 0, 1, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0,          0, 1, 0, 32'hA2,        0, 0,            0, 0, 1, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0,          0, 1, 1, 32'hA3,        0, 0,            0, 0, 1, 1, 0, 0});
      tbl.push_back('{0, 0, 0, 0,          0, 0, 0, 0,             0, 0,            0, 0, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 32'h1C000010, 32'h00001000, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 32'h1C000010, 32'h00001000, 1, 0, 0, 0, 1, 32'h00001000, 0, 1, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 32'h1C000010, 0, 0, 1, 1, 32'hB0,      0, 0,            0, 0, 0, 0, 1, 1});
      tbl.push_back('{1, 0, 32'h1C000010, 0, 0, 0, 0, 0,           0, 0,            0, 0, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 32'h1C000010, 0, 1, 0, 0, 0,           1, 32'h1C000010, 1, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0,          0, 1, 1, 32'hB1,        0, 0,            0, 0, 1, 1, 0, 0});
      tbl.push_back('{0, 0, 0, 0,          0, 1, 0, 32'hDEADBEEF,  0, 0,            0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0,          0, 0, 0, 0,             0, 0,            0, 0, 0, 0, 0, 0});

      foreach (tbl[i]) begin
         inst_if.rd_req   = tbl[i].i_req;
         inst_if.rd_addr  = tbl[i].i_addr;
         data_if.rd_req   = tbl[i].d_req;
         data_if.rd_addr  = tbl[i].d_addr;
         mem_if.rd_rdy    = tbl[i].m_rdy;
         mem_if.ret_valid = tbl[i].m_rv;
         mem_if.ret_last  = tbl[i].m_rl;
         mem_if.ret_data  = tbl[i].m_data;
         #1;
         chk($sformatf("tbl[%0d]", i),
             {mem_if.rd_req, mem_if.rd_req ? mem_if.rd_addr : 32'h0,
              inst_if.rd_rdy, data_if.rd_rdy, inst_if.ret_valid, inst_if.ret_last,
              data_if.ret_valid, data_if.ret_last},
             {tbl[i].e_req, tbl[i].e_req ? tbl[i].e_addr : 32'h0,
              tbl[i].e_irdy, tbl[i].e_drdy, tbl[i].e_irv, tbl[i].e_irl,
              tbl[i].e_drv, tbl[i].e_drl});
         cycle();
      end
      inst_if.rd_req = 0; data_if.rd_req = 0;
      mem_if.rd_rdy = 0; mem_if.ret_valid = 0; mem_if.ret_last = 0;

      // Starvation: DCache keeps re-requesting; ICache wins after two DCache bursts
      mem_if.rd_rdy   = 1;
      inst_if.rd_addr = 32'h1C000100;
      data_if.rd_addr = 32'h00002000;
      inst_if.rd_req  = 1;
      n_data = 0;
      got    = 0;
      for (int k = 0; k < 100 && !got; k++) begin
         data_if.rd_req = 1;
         bus_cycle();
         if (last_drdy) n_data++;
         if (last_irdy) got = 1;
      end
      chk("starve_grant", {31'b0, got}, 1);
      chk("starve_data_bursts", n_data, 2);
      data_if.rd_req = 0;
      drain(8);

      // Counter cleared by the grant: data wins the next contest again
      inst_if.rd_req = 1;
      data_if.rd_req = 1;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         bus_cycle();
         if (last_irdy || last_drdy) begin
            seen = 1;
            chk("starve_cleared", {last_irdy, last_drdy}, 2'b01);
         end
      end
      chk("starve_cleared_seen", {31'b0, seen}, 1);
      drain(16);

      // Delayed acceptance: request stays stable, no rdy pulse to owner
      data_if.rd_req  = 1;
      data_if.rd_type = 3'b011;
      data_if.rd_addr = 32'h0000_2040;
      mem_if.rd_rdy   = 0;
      bus_cycle();
      data_if.rd_addr = 32'hFFFF_0000;  // ignored once granted
      data_if.rd_type = 3'b111;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("stall_hold", {mem_if.rd_req, mem_if.rd_type, mem_if.rd_addr, data_if.rd_rdy},
             {1'b1, 3'b011, 32'h0000_2040, 1'b0});
         bus_cycle();
      end
      mem_if.rd_rdy = 1;
      #1;
      chk("stall_release", {31'b0, data_if.rd_rdy}, 1);
      bus_cycle();
      data_if.rd_type = 3'b001;
      drain(6);

      // Reset during the second beat, then a fresh request
      data_if.rd_req  = 1;
      data_if.rd_addr = 32'h0000_3000;
      for (int k = 0; k < 10 && beats != 3; k++) bus_cycle();
      chk("rst_mid_beats", beats, 3);
      aresetn          = 0;
      mem_if.ret_valid = 1;
      mem_if.ret_last  = 0;
      mem_if.ret_data  = 32'h5555_AAAA;
      #1;
      chk("rst_mid_outputs", dut_out(), 128'h0);
      cycle();
      beats = 0;
      mem_if.ret_valid = 0;
      aresetn = 1;
      data_if.rd_req  = 1;
      data_if.rd_addr = 32'h0000_4000;
      bus_cycle();
      #1;
      chk("post_rst_req", {mem_if.rd_req, mem_if.rd_addr}, {1'b1, 32'h0000_4000});
      drain(8);

      // Random traffic
      rnd = 1;
      for (int k = 0; k < 2000; k++) begin
         if (!inst_if.rd_req && $urandom_range(0, 3) == 0) begin
            inst_if.rd_req  = 1;
            inst_if.rd_addr = $urandom & 32'hFFFF_FFF0;
         end else if (inst_if.rd_req && $urandom_range(0, 7) == 0) begin
            inst_if.rd_addr = $urandom;
         end
         if (!data_if.rd_req && $urandom_range(0, 2) == 0) begin
            data_if.rd_req  = 1;
            data_if.rd_addr = $urandom & 32'hFFFF_FFF0;
            data_if.rd_type = 3'($urandom_range(0, 7));
         end else if (data_if.rd_req && $urandom_range(0, 7) == 0) begin
            data_if.rd_addr = $urandom;
         end
         mem_if.rd_rdy = 1'($urandom_range(0, 1));
         bus_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
